// File: rtl/fb_pkg.sv
// fb_pkg -- shared definitions for the filter bank buffer.
//   slot_state_e : per-slot load state (EMPTY, LOADING, FULL)
//   DEF_*        : default parameter values used by filter_bank_buffer
//   sel_width()  : width of a slot-select field (at least 1 bit)
package fb_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } slot_state_e;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LANES    = 4;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_NUM_FILT = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_slot.sv
// fb_slot -- one filter slot: load state, load pointer, weight storage and
// the write path for LANES weights per beat.
// Optional macro FILTER_BANK_DOUBLE_BUF_EN: two banks per slot; writes fill
// the shadow bank, reads come from the active bank, swap_i exchanges them.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         accepted write beat for this slot (already qualified)
//   wr_data_i       LANES weights, lane 0 in the LSBs
//   clr_i           empty this slot (pointer back to 0), storage kept
//   swap_i          (double-buffer build only) exchange banks if shadow FULL
//   rd_addr_i       read address into the readable bank
//   rd_word_o       weight at rd_addr_i (combinational; registered at top)
//   full_o          readable bank holds DEPTH weights
//   load_full_o     writable bank holds DEPTH weights (blocks writes)
module fb_slot
  import fb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [LANES*DATA_W-1:0] wr_data_i,
  input  logic                    clr_i,
`ifdef FILTER_BANK_DOUBLE_BUF_EN
  input  logic                    swap_i,
`endif
  input  logic [AW-1:0]           rd_addr_i,
  output logic [DATA_W-1:0]       rd_word_o,
  output logic                    full_o,
  output logic                    load_full_o
);

`ifdef FILTER_BANK_DOUBLE_BUF_EN
  localparam int IW = AW + 1;
`else
  localparam int IW = AW;
`endif

  // Pointer of the beat that completes the slot.
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - LANES);
  localparam logic [AW-1:0] PTR_STEP = AW'(LANES);

  logic [DATA_W-1:0] mem [0:(1<<IW)-1];

  slot_state_e       state_q;
  logic [AW-1:0]     ptr_q;
  logic [IW-1:0]     wbase;
  logic [IW-1:0]     ridx;
  logic [DATA_W-1:0] lane_data [LANES];

`ifdef FILTER_BANK_DOUBLE_BUF_EN
  // state_q/ptr_q track the shadow (writable) bank; the active bank is
  // either never loaded since reset/clear or FULL, so one flag suffices.
  logic active_q;
  logic active_full_q;

  assign wbase  = {~active_q, ptr_q};
  assign ridx   = {active_q, rd_addr_i};
  assign full_o = active_full_q;
`else
  assign wbase  = ptr_q;
  assign ridx   = rd_addr_i;
  assign full_o = (state_q == FULL);
`endif

  assign load_full_o = (state_q == FULL);

  // Slot state machine. The top never asserts wr_en_i while the writable
  // bank is FULL or while clr_i is set, so only the pointer check matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
`ifdef FILTER_BANK_DOUBLE_BUF_EN
      active_q      <= 1'b0;
      active_full_q <= 1'b0;
`endif
    end else if (clr_i) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
`ifdef FILTER_BANK_DOUBLE_BUF_EN
      active_full_q <= 1'b0;
`endif
    end else begin
`ifdef FILTER_BANK_DOUBLE_BUF_EN
      if (swap_i && (state_q == FULL)) begin
        active_q      <= ~active_q;
        active_full_q <= 1'b1;
        state_q       <= EMPTY;
        ptr_q         <= '0;
      end else
`endif
      if (wr_en_i) begin
        if (ptr_q == LAST_PTR) begin
          state_q <= FULL;
          ptr_q   <= '0;
        end else begin
          state_q <= LOADING;
          ptr_q   <= ptr_q + PTR_STEP;
        end
      end
    end
  end

  // Split the beat into lanes.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi] = wr_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Weight storage: never reset, never erased by clr.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int l = 0; l < LANES; l++) begin
        mem[wbase + IW'(l)] <= lane_data[l];
      end
    end
  end

  // Combinational read; the top registers the selected word, so a read in
  // the same cycle as a write sees the old contents.
  assign rd_word_o = mem[ridx];

endmodule

// File: rtl/filter_bank_buffer.sv
// filter_bank_buffer -- NUM_FILT independent filter-weight slots, each
// loaded LANES weights per beat and read one weight at a time.
// Optional macro FILTER_BANK_DOUBLE_BUF_EN adds a per-slot shadow bank and
// the swap input.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_valid/wr_ready   write handshake; wr_sel picks the slot
//   wr_data             LANES*DATA_W bits, lane 0 in the LSBs (lowest addr)
//   clr                 per-slot clear (wins over a same-cycle write)
//   swap                (double-buffer build only) per-slot bank swap
//   full                per-slot full flag (readable bank)
//   rd_en/rd_sel/rd_addr read request
//   rd_data/rd_valid    registered read result, 1 cycle after rd_en
module filter_bank_buffer
  import fb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LANES    = DEF_LANES,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_FILT = DEF_NUM_FILT,
  localparam int SEL_W   = sel_width(NUM_FILT),
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [SEL_W-1:0]        wr_sel,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic [NUM_FILT-1:0]     clr,
`ifdef FILTER_BANK_DOUBLE_BUF_EN
  input  logic [NUM_FILT-1:0]     swap,
`endif
  output logic [NUM_FILT-1:0]     full,
  input  logic                    rd_en,
  input  logic [SEL_W-1:0]        rd_sel,
  input  logic [AW-1:0]           rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid
);

  logic [NUM_FILT-1:0] slot_full;
  logic [NUM_FILT-1:0] slot_load_full;
  logic [NUM_FILT-1:0] slot_wr_en;
  logic [DATA_W-1:0]   rd_words [NUM_FILT];
  logic                wr_go;
  logic                rd_hit;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  // Ready depends only on the writable bank of the selected slot; a
  // same-cycle clear of that slot rejects the beat.
  assign wr_ready = !rst && !slot_load_full[wr_sel] && !clr[wr_sel];
  assign wr_go    = wr_valid && wr_ready;
  assign full     = slot_full;

  generate
    for (genvar gi = 0; gi < NUM_FILT; gi++) begin : g_slot
      assign slot_wr_en[gi] = wr_go && (wr_sel == SEL_W'(gi));

      fb_slot #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (slot_wr_en[gi]),
        .wr_data_i   (wr_data),
        .clr_i       (clr[gi]),
`ifdef FILTER_BANK_DOUBLE_BUF_EN
        .swap_i      (swap[gi]),
`endif
        .rd_addr_i   (rd_addr),
        .rd_word_o   (rd_words[gi]),
        .full_o      (slot_full[gi]),
        .load_full_o (slot_load_full[gi])
      );
    end
  endgenerate

  assign rd_hit = rd_en && slot_full[rd_sel];

  // Output registers; rd_data holds its value on a missed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      if (rd_hit) begin
        rd_data_q <= rd_words[rd_sel];
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/filter_bank_buffer.md
FILTER_BANK_BUFFER -- requirements
Module: filter_bank_buffer

Interface
REQ-001 Parameter DATA_W, default 8: bits per filter weight.
REQ-002 Parameter LANES, default 4: weights accepted per write beat.
REQ-003 Parameter DEPTH, default 16: weights per filter, an integer multiple of LANES.
REQ-004 Parameter NUM_FILT, default 2: independent filter slots.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port wr_valid, input, 1 bit: a write beat is offered.
REQ-008 Port wr_ready, output, 1 bit: the target slot can accept the beat.
REQ-009 Port wr_sel, input, clog2(NUM_FILT) bits: target slot of the write.
REQ-010 Port wr_data, input, LANES*DATA_W bits: lane 0 in the LSBs, stored at the lowest address.
REQ-011 Port clr, input, NUM_FILT bits: one bit per slot; a set bit empties that slot.
REQ-012 Port full, output, NUM_FILT bits: a set bit means the slot holds DEPTH weights.
REQ-013 Port rd_en, input, 1 bit: read request.
REQ-014 Port rd_sel, input, clog2(NUM_FILT) bits, and port rd_addr, input, clog2(DEPTH) bits: read slot and read address.
REQ-015 Port rd_data, output, DATA_W bits, and port rd_valid, output, 1 bit: read result and its qualifier.

Function
REQ-016 Each slot has a load pointer (0..DEPTH-LANES, step LANES) and a state EMPTY, LOADING or FULL.
REQ-017 A beat is accepted when wr_valid && wr_ready; wr_ready = !full[wr_sel] && !clr[wr_sel].
REQ-018 An accepted beat writes addresses ptr..ptr+LANES-1 and advances ptr by LANES.
REQ-019 Slot transitions: EMPTY to LOADING on the first accepted beat; LOADING to FULL on the beat that writes address DEPTH-1, with ptr wrapping to 0.
REQ-020 full[s] rises in the cycle after the final beat is accepted; a single-beat load (DEPTH==LANES) goes from EMPTY straight to FULL.
REQ-021 clr[s] forces slot s to EMPTY with ptr 0 at the next edge from any state; storage is not erased.
REQ-022 clr and a write to the same slot in the same cycle: clr wins and the beat is not accepted (wr_ready is low).
REQ-023 Writes to one slot never disturb another slot's state, pointer or data.
REQ-024 Read latency is 1 cycle: rd_en at edge N gives rd_data and rd_valid after edge N+1.
REQ-025 rd_valid = rd_en && full[rd_sel], registered; when low, rd_data holds its previous value.
REQ-026 A read and a write to the same slot in the same cycle: the read returns the old contents (read-before-write).

Reset
REQ-027 On rst: all slots EMPTY, all pointers 0, full = 0, rd_valid = 0, rd_data = 0.
REQ-028 Weight storage is not reset.
REQ-029 rst asserted mid-load abandons the load; the next beat writes address 0.
REQ-030 While rst is high, wr_ready = 0.

Configuration
REQ-031 Macro FILTER_BANK_DOUBLE_BUF_EN defined: each slot has two banks plus an input port swap (NUM_FILT bits).
REQ-032 With the macro, writes fill the shadow bank and reads use the active bank.
REQ-033 With the macro, swap[s] exchanges slot s's banks at the next edge only when shadow state is FULL; the new shadow bank becomes EMPTY.
REQ-034 With the macro, full reports the active bank, and wr_ready depends only on shadow-bank state.
REQ-035 With the macro, a swap request while the shadow bank is not FULL is ignored.
REQ-036 Macro undefined: there is a single bank and no swap port.

Structure
REQ-037 Shared package fb_pkg holds the slot-state enum (EMPTY, LOADING, FULL) and the default parameter constants.
REQ-038 One sub-module, fb_slot, implements a single slot (state, pointer, storage, write logic) and is instantiated NUM_FILT times.
REQ-039 The top level holds write steering, the read mux and the output registers.

Verification
REQ-040 Defaults; 4 beats to slot 0 with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> full = 2'b01 after beat 4; reading addr 9 returns 0x09 with rd_valid = 1 one cycle later.
REQ-041 A 5th beat to full slot 0 -> wr_ready = 0 and storage unchanged; reading slot 1 -> rd_valid = 0.
REQ-042 clr = 2'b01 together with wr_valid to slot 0 -> beat rejected, slot 0 EMPTY; the next beat writes addresses 0-3.
REQ-043 rst after 2 beats to slot 1 -> full = 0; reload of 4 beats sets full[1] one cycle after the 4th beat.
REQ-044 Interleaved beats to slot 0 and slot 1 -> each slot fills independently; all 32 addresses read back the expected values.
REQ-045 With FILTER_BANK_DOUBLE_BUF_EN: load A, swap, load B while reading A -> reads return A; after the 2nd swap, reads return B; a swap issued while the shadow bank is partly loaded is ignored.
